// File: rtl/fir_output_decimator_if.sv
// Output stream of the FIR decimator: delivered sample, its valid flag and the consumer's ready.
interface fir_output_decimator_if #(
  parameter int OUT_WIDTH = 16
);
  logic signed [OUT_WIDTH-1:0] o_data;
  logic                        o_valid;
  logic                        i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/fir_output_decimator.sv
// Decimates a full-rate FIR output, rounds and saturates it to OUT_WIDTH,
// and queues the result in a first-word-fall-through FIFO toward a ready/valid consumer.
module fir_output_decimator #(
  parameter int IN_WIDTH   = 36,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 63,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic signed [IN_WIDTH-1:0] i_data,
  fir_output_decimator_if.master     out_if,
  output logic                       o_overflow,
  output logic [15:0]                o_sat_count
);
  localparam int WARM_W = 11;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int S_W    = IN_WIDTH + 1;

  localparam logic signed [S_W-1:0] ROUND_K = S_W'(1) << (SHIFT - 1);
  localparam logic signed [S_W-1:0] SAT_MAX =
    {{(S_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [S_W-1:0] SAT_MIN =
    {{(S_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic [WARM_W-1:0]           warm_cnt_q, warm_cnt_d;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic signed [S_W-1:0]       s1_q, s1_d;
  logic                        s1_v_q, s1_v_d;
  logic signed [OUT_WIDTH-1:0] s2_q, s2_d;
  logic                        s2_v_q, s2_v_d;
  logic [15:0]                 sat_cnt_q, sat_cnt_d;
  logic [OUT_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        ovf_q, ovf_d;

  logic                        warm_done;
  logic                        capture;
  logic signed [S_W-1:0]       shifted;
  logic                        clip_hi;
  logic                        clip_lo;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        accept;

  assign warm_done = (warm_cnt_q == WARM_W'(WARMUP));
  assign capture   = warm_done && (phase_q == '0);
  assign shifted   = s1_q >>> SHIFT;
  assign clip_hi   = (shifted > SAT_MAX);
  assign clip_lo   = (shifted < SAT_MIN);

  // A push into a full FIFO is still accepted when the consumer frees a slot on the same edge.
  assign push   = s2_v_q;
  assign pop    = (count_q != '0) && out_if.i_ready;
  assign full   = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign accept = push && (!full || pop);

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    phase_d    = phase_q;
    s1_d       = s1_q;
    s1_v_d     = capture;
    s2_d       = s2_q;
    s2_v_d     = s1_v_q;
    sat_cnt_d  = sat_cnt_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (!warm_done) begin
      warm_cnt_d = warm_cnt_q + WARM_W'(1);
    end else if (phase_q == PH_W'(DECIM - 1)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end

    if (capture) begin
      s1_d = $signed({i_data[IN_WIDTH-1], i_data}) + ROUND_K;
    end

    if (s1_v_q) begin
      if (clip_hi) begin
        s2_d = OUT_MAX;
      end else if (clip_lo) begin
        s2_d = OUT_MIN;
      end else begin
        s2_d = shifted[OUT_WIDTH-1:0];
      end
      if ((clip_hi || clip_lo) && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (accept) begin
      mem_d[wr_ptr_q] = s2_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else if (push) begin
      ovf_d = 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      warm_cnt_q <= '0;
      phase_q    <= '0;
      s1_q       <= '0;
      s1_v_q     <= 1'b0;
      s2_q       <= '0;
      s2_v_q     <= 1'b0;
      sat_cnt_q  <= '0;
      mem_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      phase_q    <= phase_d;
      s1_q       <= s1_d;
      s1_v_q     <= s1_v_d;
      s2_q       <= s2_d;
      s2_v_q     <= s2_v_d;
      sat_cnt_q  <= sat_cnt_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // o_data is forced to zero whenever nothing is queued, so reset also clears it.
  assign out_if.o_valid = (count_q != '0);
  assign out_if.o_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign o_overflow     = ovf_q;
  assign o_sat_count    = sat_cnt_q;
endmodule

// File: tb/tb_fir_output_decimator.sv
// Scoreboard bench: lane 0 runs WARMUP=0/DECIM=1, lane 1 runs WARMUP=63/DECIM=4,
// each checked every cycle against an arithmetic model of rounding, decimation and the FIFO.
module tb_fir_output_decimator;
  localparam int IN_W   = 36;
  localparam int OUT_W  = 16;
  localparam int DEPTH  = 8;
  localparam longint HALF_LSB = 16384;
  localparam longint LSB      = 32768;

  typedef struct {
    int arrive;
    int val;
    bit clip;
  } sample_t;

  logic                     clk;
  logic [1:0]               rst;
  logic [1:0]               rdy;
  logic [1:0][IN_W-1:0]     din;
  int                       tests;
  int                       fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Round half toward +inf at 2^-15, then clamp to 16-bit signed.
  function automatic int expectSample(input longint x, output bit clip);
    longint y;
    longint q;
    y = x + HALF_LSB;
    if (y >= 0) q = y / LSB;
    else        q = -((-y + LSB - 1) / LSB);
    clip = (q > 32767) || (q < -32768);
    if (q > 32767)       q = 32767;
    else if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic longint randSample();
    longint v;
    case ($urandom_range(0, 3))
      0:       v = longint'({$urandom, $urandom}) >>> 28;
      1:       v = longint'($signed($urandom)) >>> 8;
      2:       v = longint'($signed($urandom)) >>> 1;
      default: v = longint'($urandom_range(0, 65535)) - 32768;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input int ln, input longint x, input bit r);
    din[ln] = x[IN_W-1:0];
    rdy[ln] = r;
    @(posedge clk);
    #2;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 0 : 63;
    localparam int D = (g == 0) ? 1 : 4;

    logic        ovf;
    logic [15:0] satc;
    fir_output_decimator_if #(.OUT_WIDTH(OUT_W)) bus ();

    fir_output_decimator #(
      .IN_WIDTH  (IN_W),
      .OUT_WIDTH (OUT_W),
      .SHIFT     (15),
      .DECIM     (D),
      .WARMUP    (W),
      .FIFO_DEPTH(DEPTH)
    ) dut (
      .i_clk      (clk),
      .i_rst      (rst[g]),
      .i_data     (din[g]),
      .out_if     (bus),
      .o_overflow (ovf),
      .o_sat_count(satc)
    );

    assign bus.i_ready = rdy[g];

    sample_t pend[$];
    int      mfifo[$];
    int      k;
    int      exp_sat;
    bit      exp_ovf;

    // Each negedge looks at the edge about to come: k is its index since reset release.
    always @(negedge clk) begin
      sample_t s;
      bit      arr;
      bit      popping;
      longint  x;
      if (rst[g]) begin
        checkOutput($sformatf("lane%0d reset o_valid", g), longint'(bus.o_valid), 0);
        checkOutput($sformatf("lane%0d reset o_data", g), longint'($signed(bus.o_data)), 0);
        checkOutput($sformatf("lane%0d reset o_overflow", g), longint'(ovf), 0);
        checkOutput($sformatf("lane%0d reset o_sat_count", g), longint'(satc), 0);
        pend.delete();
        mfifo.delete();
        k       = 0;
        exp_sat = 0;
        exp_ovf = 1'b0;
      end else begin
        arr = (pend.size() > 0) && (pend[0].arrive == k);
        if (arr && pend[0].clip && exp_sat < 65535) exp_sat++;
        checkOutput($sformatf("lane%0d o_sat_count", g), longint'(satc), exp_sat);
        checkOutput($sformatf("lane%0d o_overflow", g), longint'(ovf), longint'(exp_ovf));
        checkOutput($sformatf("lane%0d o_valid k=%0d", g, k), longint'(bus.o_valid),
                    longint'(mfifo.size() > 0));
        popping = 1'b0;
        if (mfifo.size() > 0) begin
          checkOutput($sformatf("lane%0d o_data k=%0d", g, k), longint'($signed(bus.o_data)),
                      longint'(mfifo[0]));
          popping = rdy[g];
        end
        if (popping) void'(mfifo.pop_front());
        if (arr) begin
          s = pend.pop_front();
          if (mfifo.size() >= DEPTH) exp_ovf = 1'b1;
          else                       mfifo.push_back(s.val);
        end
        if (k >= W && ((k - W) % D) == 0) begin
          x        = $signed(din[g]);
          s.arrive = k + 2;
          s.val    = expectSample(x, s.clip);
          pend.push_back(s);
        end
        k++;
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 2'b11;
    rdy   = 2'b00;
    din   = '0;
    repeat (3) @(posedge clk);
    #2;

    // Lane 0: rounding, saturation, backpressure and random traffic.
    rst[0] = 1'b0;
    applyStimulus(0, 16384, 1);
    applyStimulus(0, 16383, 1);
    applyStimulus(0, -16384, 1);
    applyStimulus(0, -16385, 1);
    applyStimulus(0, longint'(64'h8000_0000), 1);
    applyStimulus(0, -longint'(64'h8000_0000), 1);
    applyStimulus(0, longint'(32767) * LSB, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(0, longint'(i + 1) * LSB, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, randSample(), 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, randSample(), 1);
    for (int i = 0; i < 200; i++) applyStimulus(0, randSample(), $urandom_range(0, 9) < 7);

    // Lane 1: warm-up and decimation, overflow, then an asynchronous mid-stream reset.
    rdy[0] = 1'b1;
    rst[1] = 1'b0;
    for (int i = 0; i < 130; i++) applyStimulus(1, i, 1);
    for (int i = 0; i < 60; i++) applyStimulus(1, randSample(), 0);
    for (int i = 0; i < 40; i++) applyStimulus(1, longint'(i) * LSB, 1);
    for (int i = 0; i < 22; i++) applyStimulus(1, longint'(i) * LSB + longint'($urandom_range(0, 999)), 0);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst[1] = 1'b0;
    for (int i = 0; i < 100; i++) applyStimulus(1, longint'(i) * LSB, 1);
    for (int i = 0; i < 60; i++) applyStimulus(1, randSample(), $urandom_range(0, 9) < 5);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
